// File: rtl/alu_pkg.sv
// ALU control codes and multiply-sequencer state type shared across the EX stage.
package alu_pkg;

  localparam int MUL_WIDTH = 32;

  localparam logic [5:0] ALU_SLL = 6'b000000;
  localparam logic [5:0] ALU_SRL = 6'b000010;
  localparam logic [5:0] ALU_MUL = 6'b011000;
  localparam logic [5:0] ALU_ADD = 6'b100000;
  localparam logic [5:0] ALU_SUB = 6'b100010;
  localparam logic [5:0] ALU_AND = 6'b100100;
  localparam logic [5:0] ALU_OR  = 6'b100101;
  localparam logic [5:0] ALU_XOR = 6'b100110;
  localparam logic [5:0] ALU_NOR = 6'b100111;
  localparam logic [5:0] ALU_SLT = 6'b101010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/mul_stall_controller_if.sv
// EX-stage view of the multiply sequencer: ID/EX operands in, stall and product out.
interface mul_stall_controller_if;
  import alu_pkg::*;

  logic                 ExValid;
  logic [5:0]           ALUControl;
  logic [MUL_WIDTH-1:0] A;
  logic [MUL_WIDTH-1:0] B;
  logic                 Stall;
  logic                 Busy;
  logic                 ResultValid;
  logic [MUL_WIDTH-1:0] Result;

  modport master (
    output ExValid, ALUControl, A, B,
    input  Stall, Busy, ResultValid, Result
  );

  modport slave (
    input  ExValid, ALUControl, A, B,
    output Stall, Busy, ResultValid, Result
  );

endinterface

// File: rtl/mul_shift_add_dp.sv
// Shift-add multiply datapath: one partial product per step, low 32 bits kept.
module mul_shift_add_dp
  import alu_pkg::*;
(
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 load,
  input  logic                 step,
  input  logic [MUL_WIDTH-1:0] a,
  input  logic [MUL_WIDTH-1:0] b,
  output logic [MUL_WIDTH-1:0] acc,
  output logic                 last,
  output logic                 mplier_zero
);

  logic [MUL_WIDTH-1:0] mcand;
  logic [MUL_WIDTH-1:0] mplier;
  logic [4:0]           count;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
      count  <= '0;
    end else if (step) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 5'd1;
    end
  end

  assign last = (count == 5'd31);
  // Looks ahead: true when the multiplier will be zero after the current step.
  assign mplier_zero = (mplier[MUL_WIDTH-1:1] == '0);

endmodule

// File: rtl/mul_stall_controller.sv
// Multi-cycle MUL sequencer for EX; freezes the front of the pipe while iterating.
// Optional MUL_EARLY_EXIT_EN ends the iteration once the remaining multiplier bits are zero.
//
// state | meaning
// IDLE  | waiting for a valid MUL in ID/EX; stalls combinationally on trigger
// RUN   | one shift-add step per cycle, pipeline frozen
// DONE  | product presented for one cycle while the pipeline releases
module mul_stall_controller
  import alu_pkg::*;
(
  input logic                   Clk,
  input logic                   Reset,
  mul_stall_controller_if.slave bus
);

  mul_state_t           state;
  mul_state_t           state_nxt;
  logic                 trigger;
  logic                 load;
  logic                 step;
  logic                 last;
  logic                 mplier_zero;
  logic                 busy_q;
  logic [MUL_WIDTH-1:0] acc;

  assign trigger = bus.ExValid && (bus.ALUControl == ALU_MUL);

  mul_shift_add_dp u_dp (
    .Clk         (Clk),
    .Reset       (Reset),
    .load        (load),
    .step        (step),
    .a           (bus.A),
    .b           (bus.B),
    .acc         (acc),
    .last        (last),
    .mplier_zero (mplier_zero)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt == RUN);
    end
  end

  always_comb begin
    state_nxt       = state;
    load            = 1'b0;
    step            = 1'b0;
    bus.Stall       = 1'b0;
    bus.ResultValid = 1'b0;
    unique case (state)
      IDLE: begin
        bus.Stall = trigger;
        if (trigger) begin
          load = 1'b1;
`ifdef MUL_EARLY_EXIT_EN
          state_nxt = (bus.B == '0) ? DONE : RUN;
`else
          state_nxt = RUN;
`endif
        end
      end
      RUN: begin
        bus.Stall = 1'b1;
        step      = 1'b1;
`ifdef MUL_EARLY_EXIT_EN
        if (last || mplier_zero) begin
          state_nxt = DONE;
        end
`else
        if (last) begin
          state_nxt = DONE;
        end
`endif
      end
      // The MUL is still sitting in ID/EX here, so the trigger must not re-fire.
      DONE: begin
        bus.ResultValid = 1'b1;
        state_nxt       = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

`ifndef MUL_EARLY_EXIT_EN
  logic unused_mplier_zero;
  assign unused_mplier_zero = mplier_zero;
`endif

  assign bus.Busy   = busy_q;
  assign bus.Result = acc;

endmodule

// File: tb/tb_mul_stall_controller.sv
// Directed bench for mul_stall_controller; stall counts adapt to MUL_EARLY_EXIT_EN.
module tb_mul_stall_controller;
  import alu_pkg::*;

`ifdef MUL_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic Clk;
  logic Reset;
  int   checks;
  int   failures;

  mul_stall_controller_if bus ();

  mul_stall_controller dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered and left at posedge+1. Operands are scrambled after the trigger edge.
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int exp_stalls, input bit drop_after);
    int stalls;
    int busy_cycles;
    bit done;
    stalls      = 0;
    busy_cycles = 0;
    done        = 1'b0;
    bus.ExValid    = 1'b1;
    bus.ALUControl = ALU_MUL;
    bus.A          = a;
    bus.B          = b;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge Clk);
      if (bus.Stall === 1'b1) stalls++;
      if (bus.Busy === 1'b1) busy_cycles++;
      if (bus.ResultValid === 1'b1) begin
        done = 1'b1;
        check({tag, " result"}, bus.Result, exp_res);
      end
      @(posedge Clk);
      #1;
      bus.A = 32'hDEAD_BEEF;
      bus.B = 32'h1234_5678;
    end
    check({tag, " done_seen"}, {31'd0, done}, 32'd1);
    check({tag, " stall_cycles"}, stalls, exp_stalls);
    check({tag, " busy_cycles"}, busy_cycles, exp_stalls - 1);
    if (drop_after) begin
      bus.ExValid = 1'b0;
      @(negedge Clk);
      check({tag, " post_rv"}, {31'd0, bus.ResultValid}, 32'd0);
      check({tag, " post_stall"}, {31'd0, bus.Stall}, 32'd0);
      check({tag, " post_busy"}, {31'd0, bus.Busy}, 32'd0);
      check({tag, " result_held"}, bus.Result, exp_res);
      @(posedge Clk);
      #1;
    end
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    Reset          = 1'b1;
    bus.ExValid    = 1'b0;
    bus.ALUControl = 6'd0;
    bus.A          = '0;
    bus.B          = '0;

    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b0;
    @(negedge Clk);
    check("reset stall", {31'd0, bus.Stall}, 32'd0);
    check("reset busy", {31'd0, bus.Busy}, 32'd0);
    check("reset rv", {31'd0, bus.ResultValid}, 32'd0);
    check("reset result", bus.Result, 32'd0);
    @(posedge Clk);
    #1;

    bus.ExValid    = 1'b1;
    bus.ALUControl = ALU_ADD;
    bus.A          = 32'd3;
    bus.B          = 32'd5;
    @(negedge Clk);
    check("add stall", {31'd0, bus.Stall}, 32'd0);
    @(posedge Clk);
    #1;
    @(negedge Clk);
    check("add busy", {31'd0, bus.Busy}, 32'd0);
    check("add rv", {31'd0, bus.ResultValid}, 32'd0);
    check("add stall2", {31'd0, bus.Stall}, 32'd0);
    @(posedge Clk);
    #1;

    bus.ExValid    = 1'b0;
    bus.ALUControl = ALU_MUL;
    @(negedge Clk);
    check("bubble stall", {31'd0, bus.Stall}, 32'd0);
    @(posedge Clk);
    #1;
    @(negedge Clk);
    check("bubble busy", {31'd0, bus.Busy}, 32'd0);
    check("bubble rv", {31'd0, bus.ResultValid}, 32'd0);
    @(posedge Clk);
    #1;

    run_mul("mul3x5", 32'd3, 32'd5, 32'd15, EARLY ? 4 : 33, 1'b1);
    run_mul("mulneg2x7", 32'hFFFF_FFFE, 32'd7, 32'hFFFF_FFF2, EARLY ? 4 : 33, 1'b0);
    run_mul("mulallones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, 1'b1);

    bus.ExValid    = 1'b1;
    bus.ALUControl = ALU_MUL;
    bus.A          = 32'd7;
    bus.B          = 32'h8000_0009;
    repeat (10) @(posedge Clk);
    #1;
    @(negedge Clk);
    check("midrun busy", {31'd0, bus.Busy}, 32'd1);
    check("midrun stall", {31'd0, bus.Stall}, 32'd1);
    Reset       = 1'b1;
    bus.ExValid = 1'b0;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    @(negedge Clk);
    check("after_reset stall", {31'd0, bus.Stall}, 32'd0);
    check("after_reset busy", {31'd0, bus.Busy}, 32'd0);
    check("after_reset rv", {31'd0, bus.ResultValid}, 32'd0);
    check("after_reset result", bus.Result, 32'd0);
    @(posedge Clk);
    #1;

    run_mul("mul2x2", 32'd2, 32'd2, 32'd4, EARLY ? 3 : 33, 1'b1);
    run_mul("mul5x0", 32'd5, 32'd0, 32'd0, EARLY ? 1 : 33, 1'b1);
    run_mul("mul9x1", 32'd9, 32'd1, 32'd9, EARLY ? 2 : 33, 1'b1);
    run_mul("mul3xmsb", 32'd3, 32'h8000_0000, 32'h8000_0000, 33, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_stall_controller.md
# mul_stall_controller

Multi-cycle multiply sequencer in the EX stage of the pipelined MIPS datapath. It detects the R-type MUL ALU control code on the instruction held in ID/EX and computes the low 32 bits of the product with an iterative shift-add engine. While it runs, it asserts `Stall` to freeze the PC, IF/ID and ID/EX. It returns the product to the EX/MEM mux for one cycle as the pipeline releases.

## Interface
- No parameters. Operand width is fixed at 32 and the MUL code is fixed at 6'b011000.
- `Clk` in 1: single clock. All state updates on the rising edge.
- `Reset` in 1: synchronous, active-high.
- `ExValid` in 1: ID/EX holds a real (non-bubble) instruction.
- `ALUControl` in 6: ALU control code of the ID/EX instruction.
- `A` in 32: rs operand, after forwarding.
- `B` in 32: rt operand, after forwarding.
- `Stall` out 1: freeze PC, IF/ID and ID/EX. Combinational from state and inputs.
- `Busy` out 1: registered. High in RUN.
- `ResultValid` out 1: high for exactly one cycle, in DONE.
- `Result` out 32: product, low 32 bits. Held until the next capture.

## Operation
- FSM states: IDLE, RUN, DONE.
- Trigger: `ExValid && ALUControl == 6'b011000` while in IDLE.
- IDLE:
  - `Stall = trigger`.
  - On trigger: latch mcand=A, mplier=B, acc=0, count=0. Next state is RUN.
  - Otherwise stay in IDLE.
- RUN:
  - `Stall=1`.
  - Each cycle: if mplier[0], acc += mcand (mod 2^32); mcand <<= 1; mplier >>= 1; count++.
  - Exit to DONE after the iteration with count==31.
- DONE:
  - `Stall=0`, `ResultValid=1`, `Result=acc`.
  - Next state is always IDLE. The trigger is ignored in DONE because the same MUL is still in ID/EX.
- Signedness: none needed. The low 32 bits of a two's-complement product equal those of the unsigned product.
- Non-MUL codes and bubbles (`ExValid=0`) never stall.

## Timing
- Reset values: state=IDLE; `Stall`=0 when idle; `Busy`=0; `ResultValid`=0; `Result`=0; acc, mcand, mplier, count all 0.
- Reset mid-operation (RUN or DONE): next cycle is IDLE with all outputs at reset values. The in-flight product is discarded.
- Cycle sequence without early exit:
  - Cycle 0 (IDLE, trigger): `Stall=1`.
  - Cycles 1–32: RUN, `Stall=1`.
  - Cycle 33: DONE, `Stall=0`, `ResultValid=1`.
  - Total: 33 stall cycles. EX/MEM captures `Result` at the end of cycle 33.
- Back-to-back MULs: the second is triggered in the cycle after DONE (IDLE). There is no gap beyond that.
- `A` and `B` are sampled only at the trigger edge. Later changes are ignored.

## Configuration
- Macro: `MUL_EARLY_EXIT_EN`.
- Defined:
  - At trigger, if B==0, go directly to DONE with acc=0. This gives 1 stall cycle.
  - In RUN, also exit to DONE when the post-shift mplier==0.
  - RUN length = index of the highest set bit of B, plus 1.
- Undefined: RUN is always 32 cycles, independent of data.

## Structure
- Shared package `alu_pkg`:
  - ALU control code constants, including `ALU_MUL`=6'b011000, `ALU_ADD`=6'b100000 and the others.
  - The `mul_state_t` enum (IDLE, RUN, DONE).
- One sub-module, `mul_shift_add_dp`: acc, mcand and mplier registers plus the 5-bit counter. Controlled by `load` and `step` strobes; reports `last` and `mplier_zero` flags.
- The FSM and `Stall`/`ResultValid` decode stay in `mul_stall_controller`.

## Test plan
- A=3, B=5, MUL → `Stall` high for 33 cycles, then one cycle with `ResultValid=1`, `Result`=15.
- A=0xFFFFFFFE, B=7 → `Result`=0xFFFFFFF2 after 33 stall cycles.
- A=0xFFFFFFFF, B=0xFFFFFFFF → `Result`=0x00000001.
- ALUControl=6'b100000 with `ExValid=1` → `Stall`, `Busy` and `ResultValid` all 0; MUL code with `ExValid=0` → no stall.
- `Reset` asserted in RUN cycle 10 → next cycle `Stall=0`, `Busy=0`, `Result=0`. A subsequent A=2, B=2 MUL returns 4.
- With `MUL_EARLY_EXIT_EN`:
  - B=0 → 1 stall cycle, `Result`=0.
  - B=1, A=9 → 2 stall cycles, `Result`=9.
  - B=0x80000000 → 33 stall cycles.
